// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared types and constants for the UART config sequencer
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CHK,
        COMMIT,
        RESP
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

    localparam int FRAME_W        = 9;
    localparam int FRAME_DATA_LSB = 0;
    localparam int FRAME_DATA_MSB = 7;
    localparam int FRAME_PERR_BIT = 8;

    function automatic logic [7:0] frame_data(input logic [FRAME_W-1:0] f);
        return f[FRAME_DATA_MSB:FRAME_DATA_LSB];
    endfunction

    function automatic logic frame_perr(input logic [FRAME_W-1:0] f);
        return f[FRAME_PERR_BIT];
    endfunction

endpackage

// File: rtl/uart_cfg_sequencer_timeout_counter.sv
// rtl/uart_cfg_sequencer_timeout_counter.sv - inter-byte idle timer with terminal-count pulse
module timeout_counter #(
    parameter int unsigned LIMIT = 350000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // tc fires on the cycle the count would reach LIMIT; clear always wins
    assign tc = enable && !clear && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cfg_sequencer.sv
// rtl/uart_cfg_sequencer.sv - packet assembler issuing config writes and ACK/NAK responses
module uart_cfg_sequencer
    import uart_cfg_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE    = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE    = DEF_NAK_BYTE,
    parameter int unsigned TIMEOUT_CYC = 350000,
    parameter int          ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FRAME_W-1:0]  frame,
    input  logic                frame_valid,
    output logic                cfg_we,
    output logic [7:0]          cfg_addr,
    output logic [7:0]          cfg_data,
    output logic                rsp_valid,
    output logic [7:0]          rsp_byte,
    input  logic                rsp_ready,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    state_t state, next_state;

    logic [7:0] addr_q, data_q, rsp_q;
    logic [7:0] fdata;
    logic       fperr, good;
    logic       nak, overrun, to_clr, to_en, to_tc;
    logic [1:0] err_inc;
    logic [ERRCNT_W:0] err_sum;

    assign fdata = frame_data(frame);
    assign fperr = frame_perr(frame);
    assign good  = frame_valid && !fperr;

    assign to_en  = (state == ADDR) || (state == DATA) || (state == CHK);
    assign to_clr = frame_valid || (state == IDLE && next_state == ADDR);

    timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clr),
        .enable (to_en),
        .tc     (to_tc)
    );

    always_comb begin
        next_state = state;
        nak        = 1'b0;
        case (state)
            IDLE: if (good && fdata == SYNC_BYTE) next_state = ADDR;
            ADDR: begin
                if (frame_valid) begin
                    if (fperr) nak = 1'b1;
                    else       next_state = DATA;
                end else if (to_tc) begin
                    nak = 1'b1;
                end
            end
            DATA: begin
                if (frame_valid) begin
                    if (fperr) nak = 1'b1;
                    else       next_state = CHK;
                end else if (to_tc) begin
                    nak = 1'b1;
                end
            end
            CHK: begin
                if (frame_valid) begin
                    if (!fperr && fdata == (addr_q ^ data_q)) next_state = COMMIT;
                    else                                      nak = 1'b1;
                end else if (to_tc) begin
                    nak = 1'b1;
                end
            end
            COMMIT: next_state = RESP;
            RESP:   if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (nak) next_state = RESP;
    end

    // frames arriving while a write or response is in flight cannot be buffered
    assign overrun = frame_valid && (state == COMMIT || state == RESP);
    assign err_inc = {1'b0, nak} + {1'b0, overrun};
    assign err_sum = {1'b0, err_count} + (ERRCNT_W + 1)'(err_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            rsp_q     <= '0;
            err_count <= '0;
        end else begin
            state <= next_state;
            if (state == ADDR && good) addr_q <= fdata;
            if (state == DATA && good) data_q <= fdata;
            if (state == CHK && next_state == COMMIT) begin
                cfg_addr <= addr_q;
                cfg_data <= data_q;
            end
            if (nak)                  rsp_q <= NAK_BYTE;
            else if (state == COMMIT) rsp_q <= ACK_BYTE;
            err_count <= err_sum[ERRCNT_W] ? {ERRCNT_W{1'b1}} : err_sum[ERRCNT_W-1:0];
        end
    end

    assign cfg_we    = (state == COMMIT);
    assign rsp_valid = (state == RESP);
    assign rsp_byte  = rsp_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// tb/tb_uart_cfg_sequencer.sv - scoreboard bench for uart_cfg_sequencer
module tb_uart_cfg_sequencer;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] frame;
    logic       frame_valid;
    logic       cfg_we;
    logic [7:0] cfg_addr, cfg_data;
    logic       rsp_valid;
    logic [7:0] rsp_byte;
    logic       rsp_ready;
    logic       busy;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;
    int exp_err = 0;
    int we_count = 0;
    int hs_count = 0;
    logic prev_we = 1'b0;

    logic [15:0] exp_cfg[$];
    logic [7:0]  exp_rsp[$];

    uart_cfg_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .rsp_valid   (rsp_valid),
        .rsp_byte    (rsp_byte),
        .rsp_ready   (rsp_ready),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (cfg_we) begin
                logic [15:0] got;
                we_count++;
                total++;
                if (prev_we) begin
                    bad++;
                    $display("FAIL cfg_we_width: high for 2+ cycles, required 1");
                end
                total++;
                if (exp_cfg.size() == 0) begin
                    bad++;
                    $display("FAIL cfg_unexpected: addr=%h data=%h, required no write", cfg_addr, cfg_data);
                end else begin
                    got = exp_cfg.pop_front();
                    if ({cfg_addr, cfg_data} !== got) begin
                        bad++;
                        $display("FAIL cfg_write: got %h, required %h", {cfg_addr, cfg_data}, got);
                    end
                end
            end
            prev_we = cfg_we;
            if (rsp_valid && rsp_ready) begin
                logic [7:0] er;
                hs_count++;
                total++;
                if (exp_rsp.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: byte=%h, required no response", rsp_byte);
                end else begin
                    er = exp_rsp.pop_front();
                    if (rsp_byte !== er) begin
                        bad++;
                        $display("FAIL rsp_byte: got %h, required %h", rsp_byte, er);
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic perr);
        frame       = {perr, d};
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic check_err(input string name);
        total++;
        if (err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL %s: err_count=%0d, required %0d", name, err_count, exp_err);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_cfg.size() != 0 || exp_rsp.size() != 0) begin
            bad++;
            $display("FAIL %s: pending cfg=%0d rsp=%0d, required 0/0", name, exp_cfg.size(), exp_rsp.size());
        end
    endtask

    task automatic check_zero_outputs(input string name);
        total++;
        if ({cfg_we, cfg_addr, cfg_data, rsp_valid, rsp_byte, busy, err_count} !== '0) begin
            bad++;
            $display("FAIL %s: we=%b a=%h d=%h rv=%b rb=%h busy=%b err=%0d, required all 0",
                     name, cfg_we, cfg_addr, cfg_data, rsp_valid, rsp_byte, busy, err_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame = '0; frame_valid = 1'b0; rsp_ready = 1'b0;
        idle(3);
        check_zero_outputs("reset_state");
        rst = 1'b0;
        idle(2);
        check_zero_outputs("after_reset_release");
    endtask

    task automatic test_commit();
        rsp_ready = 1'b1;
        exp_cfg.push_back({8'h10, 8'h3C});
        exp_rsp.push_back(8'h06);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h10, 1'b0);
        send_frame(8'h3C, 1'b0);
        send_frame(8'h2C, 1'b0);
        total++;
        if (cfg_we !== 1'b1) begin
            bad++;
            $display("FAIL commit_latency: cfg_we=%b one cycle after CHK, required 1", cfg_we);
        end
        wait_idle(20);
        check_err("commit_err");
        check_drained("commit_drained");
    endtask

    task automatic test_bad_checksum();
        exp_rsp.push_back(8'h15);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h10, 1'b0);
        send_frame(8'h3C, 1'b0);
        send_frame(8'hFF, 1'b0);
        exp_err++;
        wait_idle(20);
        check_err("checksum_err");
        total++;
        if (cfg_addr !== 8'h10 || cfg_data !== 8'h3C) begin
            bad++;
            $display("FAIL cfg_hold: addr=%h data=%h, required 10/3c", cfg_addr, cfg_data);
        end
        check_drained("checksum_drained");
    endtask

    task automatic test_parity();
        exp_rsp.push_back(8'h15);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h10, 1'b1);
        exp_err++;
        wait_idle(20);
        check_err("parity_err");
        exp_cfg.push_back({8'h01, 8'h02});
        exp_rsp.push_back(8'h06);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h01, 1'b0);
        send_frame(8'h02, 1'b0);
        send_frame(8'h03, 1'b0);
        wait_idle(20);
        check_err("parity_recover_err");
        check_drained("parity_drained");
    endtask

    task automatic test_timeout();
        int n = 0;
        exp_rsp.push_back(8'h15);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h10, 1'b0);
        while (rsp_valid !== 1'b1 && n < TO + 20) begin
            @(posedge clk); #1;
            n++;
        end
        exp_err++;
        total++;
        if (n < TO - 1 || n > TO + 1) begin
            bad++;
            $display("FAIL timeout_latency: rsp_valid after %0d cycles, required %0d..%0d", n, TO - 1, TO + 1);
        end
        wait_idle(10);
        check_err("timeout_err");
        check_drained("timeout_drained");
    endtask

    task automatic test_overrun();
        logic stable = 1'b1;
        rsp_ready = 1'b0;
        exp_cfg.push_back({8'h20, 8'h40});
        exp_rsp.push_back(8'h06);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h20, 1'b0);
        send_frame(8'h40, 1'b0);
        send_frame(8'h60, 1'b0);
        idle(1);
        send_frame(8'h11, 1'b0);
        idle(3);
        send_frame(8'h22, 1'b0);
        exp_err += 2;
        repeat (1000) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_byte !== 8'h06) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL rsp_stable: rv=%b byte=%h at end, required held 1/06", rsp_valid, rsp_byte);
        end
        check_err("overrun_err");
        rsp_ready = 1'b1;
        wait_idle(10);
        check_drained("overrun_drained");
    endtask

    task automatic test_saturate();
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_rsp.push_back(8'h15);
            send_frame(8'hA5, 1'b0);
            send_frame(8'h00, 1'b1);
            if (exp_err < 255) exp_err++;
            idle(2);
        end
        check_err("saturate_err");
        check_drained("saturate_drained");
    endtask

    task automatic test_reset_abort();
        int we0, hs0;
        send_frame(8'hA5, 1'b0);
        send_frame(8'h30, 1'b0);
        send_frame(8'h40, 1'b0);
        rst = 1'b1;
        #1;
        check_zero_outputs("abort_reset_outputs");
        idle(2);
        rst = 1'b0;
        we0 = we_count;
        hs0 = hs_count;
        send_frame(8'h00, 1'b0);
        send_frame(8'h55, 1'b0);
        idle(20);
        check_zero_outputs("abort_ignored_frames");
        total++;
        if (we_count != we0 || hs_count != hs0) begin
            bad++;
            $display("FAIL abort_activity: writes=%0d resps=%0d, required 0/0", we_count - we0, hs_count - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_bad_checksum();
        test_parity();
        test_timeout();
        test_overrun();
        test_saturate();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
